// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder and its FIFO.
package uart_pkg;

   localparam int unsigned UART_FRAME_W = 9;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_START     = 2'd2,
      ST_WAIT_DONE = 2'd3
   } feeder_state_e;

   typedef struct packed {
      logic       parity_en;
      logic [7:0] data;
   } uart_frame_t;

   // Pack a producer request into a transmitter frame.
   function automatic uart_frame_t make_frame(input logic parity_en, input logic [7:0] data);
      uart_frame_t f;
      f.parity_en = parity_en;
      f.data      = data;
      return f;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular-buffer FIFO with registered full/empty/count flags.
// Storage is intentionally left out of reset; only pointers and flags clear.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data_c,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok   = push & ~full_q;
   assign pop_ok    = pop & ~empty_q;
   assign rd_data_c = mem[rd_ptr_q];
   assign full      = full_q;
   assign empty     = empty_q;
   assign count     = count_q;

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   // Pointer and flag registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Frame storage write port.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds queued frames to a UART transmitter with a start/busy/ready handshake.
// Optional macro UART_TX_FEEDER_TIMEOUT_EN: abandon a start request that the
// transmitter never acknowledges within START_TIMEOUT cycles and flag start_err.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned START_TIMEOUT = 2048
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_valid,
   input  logic [7:0]                  wr_data,
   input  logic                        wr_parity_en,
   output logic                        wr_ready,
   output logic                        uart_start,
   output logic [UART_FRAME_W-1:0]     uart_data,
   input  logic                        uart_ready,
   input  logic                        uart_busy,
   output logic [$clog2(DEPTH):0]      fifo_count,
   output logic                        fifo_empty,
   output logic                        overflow,
   output logic                        start_err
);

   // Parameter sanity checks at elaboration.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_feeder: DEPTH must be a power of two >= 2");
   end
   if (START_TIMEOUT < 1) begin : g_bad_timeout
      $error("uart_tx_feeder: START_TIMEOUT must be >= 1");
   end

   feeder_state_e           state_q, state_d;
   logic                    uart_start_q, uart_start_d;
   uart_frame_t             uart_data_q, uart_data_d;
   logic                    overflow_q, overflow_d;
   logic                    pop_c;
   logic                    fifo_full;
   logic [UART_FRAME_W-1:0] fifo_rdata;
   uart_frame_t             wr_frame;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(START_TIMEOUT + 1);
   logic [TW-1:0]           tmo_q, tmo_d;
   logic                    start_err_q, start_err_d;
   assign start_err = start_err_q;
`else
   assign start_err = 1'b0;
`endif

   assign wr_frame   = make_frame(wr_parity_en, wr_data);
   assign wr_ready   = ~fifo_full;
   assign uart_start = uart_start_q;
   assign uart_data  = uart_data_q;
   assign overflow   = overflow_q;

   uart_sync_fifo #(
      .WIDTH (UART_FRAME_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_valid),
      .wr_data   (wr_frame),
      .pop       (pop_c),
      .rd_data_c (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Next-state and registered-output logic for the transmit handshake.
   always_comb begin
      state_d      = state_q;
      uart_start_d = uart_start_q;
      uart_data_d  = uart_data_q;
      pop_c        = 1'b0;
      overflow_d   = overflow_q | (wr_valid & fifo_full);
`ifdef UART_TX_FEEDER_TIMEOUT_EN
      tmo_d        = tmo_q;
      start_err_d  = start_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            uart_start_d = 1'b0;
            if (!fifo_empty && uart_ready) begin
               pop_c       = 1'b1;
               uart_data_d = uart_frame_t'(fifo_rdata);
               state_d     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_d      = ST_START;
            uart_start_d = 1'b1;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
            tmo_d        = '0;
`endif
         end
         ST_START: begin
            if (uart_busy) begin
               uart_start_d = 1'b0;
               state_d      = ST_WAIT_DONE;
            end
`ifdef UART_TX_FEEDER_TIMEOUT_EN
            else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
               uart_start_d = 1'b0;
               start_err_d  = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
`endif
         end
         ST_WAIT_DONE: begin
            if (uart_ready && !uart_busy) state_d = ST_IDLE;
         end
         default: begin
            state_d      = ST_IDLE;
            uart_start_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         uart_start_q <= 1'b0;
         uart_data_q  <= '0;
         overflow_q   <= 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
         tmo_q        <= '0;
         start_err_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         uart_start_q <= uart_start_d;
         uart_data_q  <= uart_data_d;
         overflow_q   <= overflow_d;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
         tmo_q        <= tmo_d;
         start_err_q  <= start_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed/randomized bench for uart_tx_feeder with a queue-based frame model.
module tb_uart_tx_feeder;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned TMO   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic [7:0]  wr_data;
   logic        wr_parity_en;
   logic        wr_ready;
   logic        uart_start;
   logic [8:0]  uart_data;
   logic        uart_ready;
   logic        uart_busy;
   logic [4:0]  fifo_count;
   logic        fifo_empty;
   logic        overflow;
   logic        start_err;

   int total = 0;
   int bad   = 0;

   logic [8:0] exp_q[$];

   uart_tx_feeder #(
      .DEPTH         (DEPTH),
      .START_TIMEOUT (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_parity_en (wr_parity_en),
      .wr_ready     (wr_ready),
      .uart_start   (uart_start),
      .uart_data    (uart_data),
      .uart_ready   (uart_ready),
      .uart_busy    (uart_busy),
      .fifo_count   (fifo_count),
      .fifo_empty   (fifo_empty),
      .overflow     (overflow),
      .start_err    (start_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Advance one clock; inputs change and outputs are sampled at the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [8:0] f);
      wr_valid     = 1'b1;
      wr_data      = f[7:0];
      wr_parity_en = f[8];
      step();
      wr_valid     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   // Transmitter model: wait for a start request, hold it a while, then acknowledge.
   task automatic xmit(output logic [8:0] got);
      int n = 0;
      while (uart_start !== 1'b1 && n < 64) begin
         step();
         n++;
      end
      chk("xmit_start_seen", 32'(uart_start), 1);
      got = uart_data;
      repeat ($urandom_range(0, 2)) begin
         step();
         chk("start_hold", 32'(uart_start), 1);
         chk("data_hold_start", 32'(uart_data), 32'(got));
      end
      uart_busy  = 1'b1;
      uart_ready = 1'b0;
      step();
      chk("start_drop_on_busy", 32'(uart_start), 0);
      repeat ($urandom_range(0, 2)) step();
      chk("data_hold_wait", 32'(uart_data), 32'(got));
      uart_busy  = 1'b0;
      uart_ready = 1'b1;
      step();
   endtask

   initial begin
      logic [8:0] got;
      logic [8:0] f;
      int         n;

      rst = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_parity_en = 1'b0;
      uart_ready = 1'b1; uart_busy = 1'b0;
      step();
      step();
      chk("rst_wr_ready",   32'(wr_ready),   1);
      chk("rst_fifo_empty", 32'(fifo_empty), 1);
      chk("rst_count",      32'(fifo_count), 0);
      chk("rst_start",      32'(uart_start), 0);
      chk("rst_data",       32'(uart_data),  0);
      chk("rst_overflow",   32'(overflow),   0);
      chk("rst_start_err",  32'(start_err),  0);
      rst = 1'b1;

      // Single frame: start rises on the third edge counting the push edge.
      push(9'h1A5);
      chk("single_e1_start", 32'(uart_start), 0);
      chk("single_e1_count", 32'(fifo_count), 1);
      step();
      chk("single_e2_start", 32'(uart_start), 0);
      chk("single_e2_data",  32'(uart_data),  32'h1A5);
      step();
      chk("single_e3_start", 32'(uart_start), 1);
      chk("single_e3_data",  32'(uart_data),  32'h1A5);
      xmit(got);
      chk("single_frame", 32'(got), 32'h1A5);
      step();
      chk("single_empty", 32'(fifo_empty), 1);

      // Fill to DEPTH with the transmitter not ready, then one extra offer.
      uart_ready = 1'b0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         f = 9'($urandom);
         exp_q.push_back(f);
         push(f);
      end
      chk("fill_count",    32'(fifo_count), DEPTH);
      chk("fill_wr_ready", 32'(wr_ready),   0);
      chk("fill_overflow_before", 32'(overflow), 0);
      push(9'($urandom));
      chk("fill_overflow", 32'(overflow),   1);
      chk("fill_count_17", 32'(fifo_count), DEPTH);
      uart_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         xmit(got);
         chk("fill_drain_order", 32'(got), 32'(exp_q.pop_front()));
      end
      step();
      chk("fill_overflow_sticky", 32'(overflow),   1);
      chk("fill_drained_empty",   32'(fifo_empty), 1);
      do_reset();
      chk("fill_overflow_cleared", 32'(overflow), 0);

      // Wrap: 20 frames pushed while a transmitter drains concurrently.
      fork
         begin : producer
            for (int i = 0; i < 20; i++) begin
               int w = 0;
               while (wr_ready !== 1'b1 && w < 200) begin
                  step();
                  w++;
               end
               chk("wrap_ready_wait", 32'(wr_ready), 1);
               push(9'(i));
               repeat ($urandom_range(0, 2)) step();
            end
         end
         begin : consumer
            logic [8:0] g;
            for (int i = 0; i < 20; i++) begin
               xmit(g);
               chk("wrap_order", 32'(g), 32'(i));
            end
         end
      join
      chk("wrap_no_overflow", 32'(overflow),   0);
      chk("wrap_empty",       32'(fifo_empty), 1);

      // Simultaneous push and pop with five frames queued.
      uart_ready = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         f = 9'($urandom);
         exp_q.push_back(f);
         push(f);
      end
      chk("pp_count_before", 32'(fifo_count), 5);
      f = 9'($urandom);
      exp_q.push_back(f);
      uart_ready = 1'b1;
      push(f);
      chk("pp_count_same", 32'(fifo_count), 5);
      for (int i = 0; i < 6; i++) begin
         xmit(got);
         chk("pp_order", 32'(got), 32'(exp_q.pop_front()));
      end

      // Reset while a start request is pending.
      push(9'($urandom));
      push(9'($urandom));
      push(9'($urandom));
      n = 0;
      while (uart_start !== 1'b1 && n < 16) begin
         step();
         n++;
      end
      chk("rstmid_in_start", 32'(uart_start), 1);
      do_reset();
      chk("rstmid_start", 32'(uart_start), 0);
      chk("rstmid_count", 32'(fifo_count), 0);
      chk("rstmid_empty", 32'(fifo_empty), 1);
      chk("rstmid_data",  32'(uart_data),  0);
      f = 9'($urandom);
      push(f);
      chk("rstmid_idle_e1", 32'(uart_start), 0);
      step();
      chk("rstmid_idle_e2", 32'(uart_start), 0);
      step();
      chk("rstmid_idle_e3", 32'(uart_start), 1);
      xmit(got);
      chk("rstmid_frame", 32'(got), 32'(f));

      // Unacknowledged start request.
      f = 9'($urandom);
      push(f);
      n = 0;
      while (uart_start !== 1'b1 && n < 16) begin
         step();
         n++;
      end
      chk("tmo_start_seen", 32'(uart_start), 1);
`ifdef UART_TX_FEEDER_TIMEOUT_EN
      n = 0;
      while (uart_start === 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("tmo_cycles",    32'(n),          TMO);
      chk("tmo_start_err", 32'(start_err),  1);
      chk("tmo_count",     32'(fifo_count), 0);
      f = 9'($urandom);
      push(f);
      step();
      step();
      chk("tmo_idle_restart", 32'(uart_start), 1);
      xmit(got);
      chk("tmo_next_frame", 32'(got), 32'(f));
      chk("tmo_err_sticky", 32'(start_err), 1);
`else
      repeat (3 * TMO) step();
      chk("notmo_still_start", 32'(uart_start), 1);
      chk("notmo_start_err",   32'(start_err),  0);
      xmit(got);
      chk("notmo_frame", 32'(got), 32'(f));
`endif

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
